// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings and FSM state type.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_shift_core.sv
// Unsigned shift datapath: radix-2 shift-add multiply or restoring
// divide over a 2*WIDTH accumulator, plus the iteration counter.
module muldiv_shift_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   yreg;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_nxt;

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0])
            mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, yreg};
        sh   = {acc, 1'b0};
        diff = sh[2*WIDTH:WIDTH] - {1'b0, yreg};
        if (!is_div)
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        else if (diff[WIDTH])
            acc_nxt = sh[2*WIDTH-1:0];
        else
            acc_nxt = {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            yreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            acc  <= {{WIDTH{1'b0}}, x};
            yreg <= y;
            cnt  <= '0;
        end else if (step) begin
            acc  <= acc_nxt;
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit feeding Hi/Lo.
// Define MULDIV_UNSIGNED_EN to enable the multu/divu variants.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    muldiv_state_t state, state_nxt;

    logic               uns;
    logic               accept;
    logic               load;
    logic               step;
    logic               last;
    logic               is_div_q;
    logic               bz_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   xa;
    logic [WIDTH-1:0]   yb;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

`ifdef MULDIV_UNSIGNED_EN
    assign uns = op[1];
    assign xa  = (!uns && a[WIDTH-1]) ? -a : a;
    assign yb  = (!uns && b[WIDTH-1]) ? -b : b;
`else
    assign uns = 1'b0 & op[1];
    assign xa  = a[WIDTH-1] ? -a : a;
    assign yb  = b[WIDTH-1] ? -b : b;
`endif

    assign accept = (state == IDLE) && start;
    assign busy   = (state == RUN) || (state == FIX);
    assign done   = (state == DONE);
    assign load   = accept;

    assign prod = neg_res_q ? -acc : acc;
    assign quo  = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    muldiv_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (is_div_q),
        .x      (xa),
        .y      (yb),
        .acc    (acc),
        .last   (last)
    );

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (is_div_q && bz_q) begin
                    state_nxt = DONE;
                end else begin
                    step = 1'b1;
                    if (last) state_nxt = FIX;
                end
            end
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            is_div_q  <= 1'b0;
            bz_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                is_div_q  <= (op == OP_DIV) || (op == OP_DIVU);
                bz_q      <= (b == '0);
                neg_res_q <= !uns && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem_q <= !uns && a[WIDTH-1];
                div_zero  <= 1'b0;
            end
            // Divide by zero skips the datapath and leaves hi/lo untouched
            if (state == RUN && is_div_q && bz_q)
                div_zero <= 1'b1;
            if (state == FIX) begin
                if (is_div_q) begin
                    hi <= rem;
                    lo <= quo;
                end else begin
                    hi <= prod[2*WIDTH-1:WIDTH];
                    lo <= prod[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) with a behavioural
// arithmetic reference model; honours MULDIV_UNSIGNED_EN.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        logic uns;
        longint sx, sy, q, r, p;
        logic [63:0] up;
`ifdef MULDIV_UNSIGNED_EN
        uns = o[1];
`else
        uns = 1'b0;
`endif
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o[0]) begin
            if (y == '0) begin
                m_dz = 1'b1;
            end else begin
                m_dz = 1'b0;
                if (uns) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = q[W-1:0];
                    m_hi = r[W-1:0];
                end
            end
        end else begin
            m_dz = 1'b0;
            if (uns) begin
                up = {32'b0, x} * {32'b0, y};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end else begin
                p = sx * sy;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input string tag);
        int n;
        int lat;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        chk({tag, "_busy1"}, 64'(busy), 64'(1'b1));
        n = 1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        model(o, x, y);
        lat = (o[0] && y == '0) ? 2 : W + 2;
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
        chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
        chk({tag, "_dz"}, 64'(div_zero), 64'(m_dz));
    endtask

    initial begin
        logic seen;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;

        #23;
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(1'b0));
        reset = 1'b0;

        run_op(2'b00, 32'd7, -32'sd3, "t1");
        chk("t1_hic", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("t1_loc", 64'(lo), 64'h0000_0000_FFFF_FFEB);
        run_op(2'b01, -32'sd7, 32'd2, "t2");
        chk("t2_loc", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("t2_hic", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        run_op(2'b01, 32'd5, 32'd0, "t3");
        chk("t3_hic", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("t3_loc", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("t3_dzc", 64'(div_zero), 64'(1'b1));
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "t4");
        chk("t4_loc", 64'(lo), 64'h0000_0000_8000_0000);
        chk("t4_hic", 64'(hi), 64'(0));
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t5m");
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10, "t5d");
`ifdef MULDIV_UNSIGNED_EN
        chk("t5d_loc", 64'(lo), 64'h0000_0000_0FFF_FFFF);
        chk("t5d_hic", 64'(hi), 64'h0000_0000_0000_000F);
`else
        chk("t5d_loc", 64'(lo), 64'(0));
        chk("t5d_hic", 64'(hi), 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ro, ra, rb, $sformatf("rnd%0d", i));
        end

        run_op(2'b00, 32'h1234_5678, 32'h0000_0F00, "t6pre");
        @(negedge clk);
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 5; c++) @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy_mid", 64'(busy), 64'(1'b1));
        for (int c = 6; c < 10; c++) @(negedge clk);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("t6_busy", 64'(busy), 64'(1'b0));
        chk("t6_hi", 64'(hi), 64'(0));
        chk("t6_lo", 64'(lo), 64'(0));
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        chk("t6_nodone", 64'(seen), 64'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
